// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard detection inputs and pipeline stall/flush controls for hazard_ctrl
// slave  (hazard_ctrl): reads ID/EX and IF/ID register fields and branch_taken, drives the controls and counters
// master (pipeline)   : drives register fields and branch_taken, reads the controls and counters
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic if_id_uses_rs2;
  logic id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic branch_taken;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_mem_read, id_ex_rd, branch_taken,
    input pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, stall_count, flush_count
  );
  modport slave (
    input if_id_rs1, if_id_rs2, if_id_uses_rs2, id_ex_mem_read, id_ex_rd, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush control with saturating event counters
// clk, reset (async, active-high) plus hazard_ctrl_if.slave h carrying the hazard inputs,
// the pc_write/if_id_write/flush controls and the stall_count/flush_count counters
module hazard_ctrl #(parameter int CNT_W = 32) (
  input logic clk,
  input logic reset,
  hazard_ctrl_if.slave h
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;
  logic [0:0] state;
  logic luh, stall, bt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  assign bt = h.branch_taken;
  assign luh = h.id_ex_mem_read & (h.id_ex_rd != 5'd0) &
               ((h.id_ex_rd == h.if_id_rs1) | (h.if_id_uses_rs2 & (h.id_ex_rd == h.if_id_rs2)));
  // REDIRECT masks luh because IF/ID holds a flushed NOP; a taken branch overrides any stall
  assign stall = ~bt & (state == RUN) & luh;
  always_comb begin
    h.pc_write = ~stall;
    h.if_id_write = ~stall;
    h.if_id_flush = bt;
    h.id_ex_flush = bt | stall;
    h.ex_mem_flush = bt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= bt ? REDIRECT : RUN;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (bt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  assign h.stall_count = stall_cnt;
  assign h.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus reset, saturation and async reset sequences
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  hazard_ctrl_if #(.CNT_W(4)) h();
  hazard_ctrl #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .h(h));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic u2;
    logic mr;
    logic [4:0] rd;
    logic bt;
    logic [4:0] out;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;
  vec_t v[15];
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] BR = 5'b11111;
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic bt);
    h.if_id_rs1 = rs1;
    h.if_id_rs2 = rs2;
    h.if_id_uses_rs2 = u2;
    h.id_ex_mem_read = mr;
    h.id_ex_rd = rd;
    h.branch_taken = bt;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [4:0] outs();
    return {h.pc_write, h.if_id_write, h.if_id_flush, h.id_ex_flush, h.ex_mem_flush};
  endfunction
  initial begin
    v[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, DEF, 4'd0, 4'd0};
    v[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL, 4'd0, 4'd0};
    v[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, DEF, 4'd1, 4'd0};
    v[3]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, DEF, 4'd1, 4'd0};
    v[4]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, DEF, 4'd1, 4'd0};
    v[5]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, STL, 4'd1, 4'd0};
    v[6]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, BR,  4'd2, 4'd0};
    v[7]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, DEF, 4'd2, 4'd1};
    v[8]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL, 4'd2, 4'd1};
    v[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, BR,  4'd3, 4'd1};
    v[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, BR,  4'd3, 4'd2};
    v[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, BR,  4'd3, 4'd3};
    v[12] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, DEF, 4'd3, 4'd4};
    v[13] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, STL, 4'd3, 4'd4};
    v[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, DEF, 4'd4, 4'd4};
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_counters", {h.stall_count, h.flush_count}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle_outs", outs(), DEF);
      chk("idle_counts", {h.stall_count, h.flush_count}, 8'h00);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i].rs1, v[i].rs2, v[i].u2, v[i].mr, v[i].rd, v[i].bt);
      #1;
      chk($sformatf("vec%0d_outs", i), outs(), v[i].out);
      chk($sformatf("vec%0d_stall_count", i), h.stall_count, v[i].sc);
      chk($sformatf("vec%0d_flush_count", i), h.flush_count, v[i].fc);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(5, 0, 0, 1, 5, 0);
    end
    #1;
    chk("sat_stall_outs", outs(), STL);
    chk("sat_stall_count", h.stall_count, 4'd15);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1);
    end
    #1;
    chk("sat_flush_outs", outs(), BR);
    chk("sat_flush_count", h.flush_count, 4'd15);
    chk("sat_stall_held", h.stall_count, 4'd15);
    @(negedge clk);
    drive(5, 0, 0, 1, 5, 0);
    #1;
    chk("redirect_mask", outs(), DEF);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_counts", {h.stall_count, h.flush_count}, 8'h00);
    chk("async_rst_run_stall", outs(), STL);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_stall_count", h.stall_count, 4'd1);
    chk("post_rst_flush_count", h.flush_count, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the stall and flush inputs of the IF/ID and ID/EX pipeline registers in the 5-stage 64-bit RISC-V core. It detects load-use hazards between the instruction in ID and the load in EX, and inserts one bubble by stalling PC and IF/ID while flushing ID/EX. It also squashes wrong-path instructions when a branch resolves taken in MEM. Saturating stall and flush event counters support performance debug.

## Interface
- CNT_W, 32, width of the stall_count and flush_count event counters
- clk  input  1  pipeline clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears FSM state and counters
- if_id_rs1  input  5  rs1 field of the instruction currently in IF/ID
- if_id_rs2  input  5  rs2 field of the instruction currently in IF/ID
- if_id_uses_rs2  input  1  1 if the ID instruction reads rs2 (R-type, S-type, B-type)
- id_ex_mem_read  input  1  mem_read output of the ID/EX register
- id_ex_rd  input  5  rd output of the ID/EX register
- branch_taken  input  1  branch in EX/MEM resolved taken this cycle (branch & zero)
- pc_write  output  1  1 = PC may update; 0 = hold PC
- if_id_write  output  1  1 = IF/ID may load; 0 = hold IF/ID
- if_id_flush  output  1  zero the IF/ID contents at the next edge
- id_ex_flush  output  1  load a bubble (all controls 0) into ID/EX
- ex_mem_flush  output  1  kill the control bits entering EX/MEM
- stall_count  output  CNT_W  number of load-use stall cycles since reset, saturating
- flush_count  output  CNT_W  number of branch-flush events since reset, saturating

## Operation
- FSM states are RUN and REDIRECT; reset enters RUN.
- The load-use condition is luh = id_ex_mem_read & (id_ex_rd != 0) & ((id_ex_rd == if_id_rs1) | (if_id_uses_rs2 & id_ex_rd == if_id_rs2)).
- Outputs are combinational from the current state and inputs. The default output values are pc_write=1, if_id_write=1, and all three flush outputs 0.
- Priority 1: branch_taken=1 (any state).
  - Drives if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - pc_write=1 so the target loads; if_id_write=1.
  - Load-use stalling is ignored this cycle.
  - Next state is REDIRECT, and flush_count is incremented.
- Priority 2: state RUN with luh=1.
  - Drives pc_write=0, if_id_write=0, id_ex_flush=1. The other flushes stay 0.
  - stall_count is incremented and the state stays RUN.
- REDIRECT without branch_taken:
  - Outputs take their default values. luh is masked because IF/ID holds a flushed NOP.
  - Next state is RUN.
- RUN with neither event: default outputs and the state stays RUN.
- Counters saturate at 2^CNT_W-1 and never wrap.
- rd = x0 never causes a stall.
- A store whose rs2 matches a load rd stalls (if_id_uses_rs2=1).

## Timing
- Detection has zero-cycle latency: flush and stall outputs are valid in the same cycle the condition is present and act at the next rising edge of clk.
- A load-use hazard costs exactly 1 stall cycle. On the following cycle ID/EX holds the bubble, id_ex_mem_read=0, and luh deasserts without FSM help.
- A taken branch costs 3 squashed slots (IF/ID, ID/EX, EX/MEM) and 1 REDIRECT cycle.
- Back-to-back branch_taken, including in REDIRECT: every cycle flushes, counts, and stays in or enters REDIRECT.
- branch_taken and luh in the same cycle: only the branch action is taken; stall_count does not increment.
- Reset is asynchronous and mid-operation. While reset=1:
  - state=RUN and both counters are 0.
  - Outputs take the RUN combinational values, so a luh during reset still drives the stall pattern. Downstream registers are held in reset by the same signal.
- Counter updates are visible on the cycle after the triggering edge.

## Test plan
- Reset and idle: assert reset, release, hold all inputs 0 for 5 cycles -> pc_write=1, if_id_write=1, all flushes 0, stall_count=0, flush_count=0.
- Load-use on rs1: id_ex_mem_read=1, id_ex_rd=5, if_id_rs1=5 for 1 cycle, then id_ex_mem_read=0 -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle defaults; stall_count=1.
- No stall on x0 or unused rs2: id_ex_rd=0 with if_id_rs1=0 -> no stall. id_ex_rd=7, if_id_rs2=7, if_id_uses_rs2=0 -> no stall. stall_count stays 0.
- Branch taken with simultaneous luh: branch_taken=1 and the luh condition true -> all three flushes 1, pc_write=1, flush_count=1, stall_count=0. Next cycle with luh still true -> REDIRECT masks it; defaults; then RUN.
- Consecutive branches: branch_taken=1 for 3 cycles -> flushes asserted each cycle, flush_count=3, REDIRECT held, RUN one cycle after deassert.
- Saturation and async reset: CNT_W=4, 20 stall cycles -> stall_count=15. Pulse reset between clock edges -> counters 0 immediately, state RUN.
